pwm_center_aligned_dt_nch: RTL and testbench
============================================

Name: pwm_center_aligned_dt_nch

Overview:
N-channel center-aligned PWM generator for the vector-control inverter stage. It generalises the fixed 3-phase triangle/comparator PWM with the following:
- an unsigned up/down carrier with a runtime period
- shadowed duty registers updated only at the carrier valley
- per-channel registered dead-time state machines
- an enable input and a fault kill input

It sits between the vector-control voltage outputs (already scaled to carrier units) and the gate-driver pins.

Parameters:
N_CH, 3, number of half-bridge channels
W, 16, carrier/duty/period width in bits
DT_W, 8, dead-time counter width
DT, 35, dead time in clk cycles (0 = no dead time)
PERIOD_RST, 16'd1000, carrier peak value after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run carrier and outputs; low = idle
period  in  W  carrier peak value; sampled at valley
duty  in  N_CH*W  per-channel compare values, channel k at [k*W +: W]
load  in  1  one-cycle strobe: capture duty into pending shadow
fault  in  1  gate-driver fault; kills all outputs
out_p  out  N_CH  high-side gate drive
out_n  out  N_CH  low-side gate drive
carrier  out  W  current carrier value
carrier_up  out  1  1 = counting up
sync  out  1  one-cycle pulse at carrier valley (ADC trigger)

Behaviour:
- Reset (async, active-high):
  - carrier=0, carrier_up=1, period_reg=PERIOD_RST
  - pending/active duty=0, pend_valid=0, sync=0
  - out_p=out_n=0, every dead counter=DT
- Carrier:
  - +1 per clk while carrier_up; -1 otherwise.
  - At carrier==period_reg while up: direction flips, so the next value is period_reg-1.
  - At carrier==1 while down: the next value is 0 and carrier_up=1.
  - One full cycle = 2*period_reg clocks. Sequence: 0,1..P,P-1..1, then 0.
- Valley event (carrier==0):
  - sync=1 on that cycle.
  - period_reg <= max(period, 2).
  - If pend_valid: active duty <= pending, pend_valid <= 0.
- load:
  - Captures duty into pending and sets pend_valid, on any cycle.
  - load on the valley cycle applies at the next valley, not the current one.
  - A later load before the valley overwrites pending.
- Compare (combinational on registered carrier): raw_k = active_duty_k > carrier.
  - duty=0 gives raw always 0.
  - duty>period_reg gives raw always 1.
- Dead-time FSM per channel. States DEAD, P_ON, N_ON.
  - Any change of raw_k versus the previous cycle: state -> DEAD, counter reloads DT.
  - In DEAD: the counter decrements each cycle. At 0, go to P_ON if raw_k=1, else N_ON.
  - Pulses shorter than DT are swallowed: both outputs stay low.
  - DT=0: outputs follow raw with 1-cycle latency.
  - out_p = (state==P_ON), out_n = (state==N_ON), both registered.
  - out_p & out_n is never 1.
- enable=0:
  - carrier is held at 0, up=1; sync=0.
  - All FSMs are forced to DEAD with counter=DT, so all outputs are low.
  - After enable rises, the first DT cycles have both outputs low.
- fault: combinationally gates out_p/out_n to 0 in the same cycle. Carrier and FSMs keep running.
- Reset mid-operation: all state returns to reset values immediately. No partial pulse survives.

Optional Feature:
- Macro PWM_FAULT_LATCH_EN.
- Defined:
  - fault sets a sticky fault_latched register; outputs stay 0 while it is set.
  - fault_latched clears only by reset or by enable being low for at least 1 cycle while fault=0.
  - An extra output port fault_latched (1 bit) is added.
- Undefined: fault gating is purely combinational and non-sticky, and no extra port exists.

Test Plan:
1. W=12, period=100, enable=1 after reset -> carrier runs 0..100..0; sync pulses exactly every 200 clk; carrier_up flips at 100 and at 0.
2. DT=5, duty=50 on all channels -> per 200-clk period: out_p high 94 clk, out_n high 96 clk, two 5-clk both-low gaps; out_p&out_n never 1.
3. Duty change:
   - Stimulus: load with duty=80 at carrier=40 (up).
   - Old duty 50 holds until the next sync; the new duty applies from that valley on.
   - A second load before the valley overwrites the first.
4. DT=5, duty=2 -> raw high 3 clk (carrier 1,0,1) -> out_p never high; out_n low for 8 clk around each valley.
5. fault:
   - fault=1 mid-P_ON -> out_p=0 in the same cycle.
   - Without the macro: outputs resume when fault=0.
   - With PWM_FAULT_LATCH_EN: outputs stay 0 until an enable low pulse while fault=0.
6. Async reset asserted at carrier=73 (down) -> carrier=0, outputs 0 with no clock edge needed; restart matches scenario 1 with the PERIOD_RST peak.

Source files
------------

// File: rtl/pwm_center_aligned_dt_nch.sv
// N-channel center-aligned PWM: up/down carrier, valley-shadowed duty, per-channel dead time, enable and fault kill.
// Optional: define PWM_FAULT_LATCH_EN to make fault sticky and add the fault_latched output.
module pwm_center_aligned_dt_nch #(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned W          = 16,
    parameter int unsigned DT_W       = 8,
    parameter int unsigned DT         = 35,
    parameter logic [W-1:0] PERIOD_RST = W'(1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [W-1:0]      period,
    input  logic [N_CH*W-1:0] duty,
    input  logic              load,
    input  logic              fault,
    output logic [N_CH-1:0]   out_p,
    output logic [N_CH-1:0]   out_n,
    output logic [W-1:0]      carrier,
    output logic              carrier_up,
    output logic              sync
`ifdef PWM_FAULT_LATCH_EN
    ,
    output logic              fault_latched
`endif
);

    localparam logic [W-1:0]    PERIOD_MIN = W'(2);
    localparam logic [DT_W-1:0] DT_LOAD    = DT_W'(DT);
    localparam bit              HAS_DT     = (DT != 0);

    typedef enum logic [1:0] {DEAD, P_ON, N_ON} deadState_t;

    logic [W-1:0]      periodReg;
    logic [N_CH*W-1:0] pendDuty;
    logic [N_CH*W-1:0] actDuty;
    logic              pendValid;
    logic              valley;
    logic              killOut;
    logic [N_CH-1:0]   raw;
    logic [N_CH-1:0]   pReg;
    logic [N_CH-1:0]   nReg;

    // sync is registered one cycle ahead so it is high exactly while the carrier sits at the valley
    assign valley = sync & enable;

    // Triangle carrier: 0,1..P,P-1..1 then back to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carrier    <= '0;
            carrier_up <= 1'b1;
            sync       <= 1'b0;
            periodReg  <= PERIOD_RST;
        end else if (!enable) begin
            carrier    <= '0;
            carrier_up <= 1'b1;
            sync       <= 1'b0;
        end else begin
            sync <= !carrier_up && (carrier == W'(1));
            if (valley) begin
                periodReg <= (period < PERIOD_MIN) ? PERIOD_MIN : period;
            end
            if (carrier_up) begin
                if (carrier >= periodReg) begin
                    carrier    <= carrier - W'(1);
                    carrier_up <= 1'b0;
                end else begin
                    carrier <= carrier + W'(1);
                end
            end else if (carrier <= W'(1)) begin
                carrier    <= '0;
                carrier_up <= 1'b1;
            end else begin
                carrier <= carrier - W'(1);
            end
        end
    end

    // Duty shadow: load fills pending, valley moves pending to active; load wins over the valley clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendDuty  <= '0;
            actDuty   <= '0;
            pendValid <= 1'b0;
        end else begin
            if (valley && pendValid) begin
                actDuty <= pendDuty;
            end
            if (load) begin
                pendDuty  <= duty;
                pendValid <= 1'b1;
            end else if (valley) begin
                pendValid <= 1'b0;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            raw[k] = actDuty[k*W +: W] > carrier;
        end
    end

    for (genvar k = 0; k < int'(N_CH); k++) begin : gCh
        deadState_t      state;
        logic [DT_W-1:0] deadCnt;
        logic            prevRaw;
        logic            pOn;
        logic            nOn;

        // Dead-time FSM: any edge of raw restarts the both-off window
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= DEAD;
                deadCnt <= DT_LOAD;
                prevRaw <= 1'b0;
                pOn     <= 1'b0;
                nOn     <= 1'b0;
            end else begin
                prevRaw <= raw[k];
                if (!enable) begin
                    state   <= DEAD;
                    deadCnt <= DT_LOAD;
                    pOn     <= 1'b0;
                    nOn     <= 1'b0;
                end else if ((raw[k] != prevRaw) && HAS_DT) begin
                    state   <= DEAD;
                    deadCnt <= DT_LOAD;
                    pOn     <= 1'b0;
                    nOn     <= 1'b0;
                end else if ((raw[k] != prevRaw) || ((state == DEAD) && (deadCnt <= DT_W'(1)))) begin
                    state   <= raw[k] ? P_ON : N_ON;
                    deadCnt <= '0;
                    pOn     <= raw[k];
                    nOn     <= !raw[k];
                end else if (state == DEAD) begin
                    deadCnt <= deadCnt - DT_W'(1);
                end
            end
        end

        assign pReg[k] = pOn;
        assign nReg[k] = nOn;
    end

`ifdef PWM_FAULT_LATCH_EN
    // Sticky fault: cleared by reset or a disabled cycle with fault released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (!enable) begin
            fault_latched <= 1'b0;
        end
    end
    assign killOut = fault | fault_latched;
`else
    assign killOut = fault;
`endif

    // Fault must kill the gates in the same cycle, so it bypasses the output registers
    assign out_p = pReg & {N_CH{!killOut}};
    assign out_n = nReg & {N_CH{!killOut}};

endmodule

// File: tb/tb_pwm_center_aligned_dt_nch.sv
// Bench for pwm_center_aligned_dt_nch: random stimulus against a phase/window reference model plus directed scenarios.
// Honours PWM_FAULT_LATCH_EN when compiled with it.
module tb_pwm_center_aligned_dt_nch;
    localparam int unsigned N_CH = 3;
    localparam int unsigned W    = 12;
    localparam int unsigned DT_W = 8;
    localparam int unsigned DT   = 5;
    localparam int unsigned PRST = 100;
    localparam int unsigned HIST = DT + 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              load;
    logic              fault;
    logic [W-1:0]      period;
    logic [N_CH*W-1:0] duty;
    logic [N_CH-1:0]   out_p;
    logic [N_CH-1:0]   out_n;
    logic [W-1:0]      carrier;
    logic              carrier_up;
    logic              sync;
`ifdef PWM_FAULT_LATCH_EN
    logic              fault_latched;
    bit                faultL;
`endif

    int total;
    int bad;

    // Reference model state: position within the current carrier cycle
    int  phase;
    int  curP;
    bit  wrapped;
    bit  pendV;
    int  actD  [N_CH];
    int  pendD [N_CH];
    bit  rawH  [N_CH][HIST];
    bit  enH   [HIST];

    logic [N_CH-1:0] obsP;
    logic [N_CH-1:0] obsN;
    logic            obsSync;

    pwm_center_aligned_dt_nch #(
        .N_CH(N_CH), .W(W), .DT_W(DT_W), .DT(DT), .PERIOD_RST(W'(PRST))
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .duty(duty),
        .load(load), .fault(fault), .out_p(out_p), .out_n(out_n),
        .carrier(carrier), .carrier_up(carrier_up), .sync(sync)
`ifdef PWM_FAULT_LATCH_EN
        , .fault_latched(fault_latched)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mCarrier();
        return (phase <= curP) ? phase : 2 * curP - phase;
    endfunction

    function automatic bit mUp();
        return phase <= curP;
    endfunction

    // Output is on once the raw level has held for DT+1 cycles with the block enabled throughout
    function automatic bit mOut(input int k, input bit pol);
        int enWin;
        enWin = (DT > 0) ? int'(DT) : 1;
        for (int i = 0; i <= int'(DT); i++) if (rawH[k][i] != pol) return 1'b0;
        for (int i = 0; i < enWin; i++) if (!enH[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        phase = 0; curP = int'(PRST); wrapped = 1'b0; pendV = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            actD[k] = 0; pendD[k] = 0;
            for (int i = 0; i < int'(HIST); i++) rawH[k][i] = 1'b0;
        end
        for (int i = 0; i < int'(HIST); i++) enH[i] = 1'b0;
`ifdef PWM_FAULT_LATCH_EN
        faultL = 1'b0;
`endif
    endtask

    task automatic modelEdge();
        int c;
        c = mCarrier();
        for (int k = 0; k < int'(N_CH); k++) begin
            for (int i = int'(HIST) - 1; i > 0; i--) rawH[k][i] = rawH[k][i-1];
            rawH[k][0] = actD[k] > c;
        end
        for (int i = int'(HIST) - 1; i > 0; i--) enH[i] = enH[i-1];
        enH[0] = enable;
`ifdef PWM_FAULT_LATCH_EN
        if (fault) faultL = 1'b1;
        else if (!enable) faultL = 1'b0;
`endif
        if (wrapped && enable) begin
            curP = (int'(period) < 2) ? 2 : int'(period);
            if (pendV) begin
                actD = pendD;
                pendV = 1'b0;
            end
        end
        if (load) begin
            for (int k = 0; k < int'(N_CH); k++) pendD[k] = int'(duty[k*W +: W]);
            pendV = 1'b1;
        end
        if (!enable) begin
            phase = 0; wrapped = 1'b0;
        end else begin
            phase++;
            if (phase >= 2 * curP) begin
                phase = 0; wrapped = 1'b1;
            end else begin
                wrapped = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        logic [N_CH-1:0] eP;
        logic [N_CH-1:0] eN;
        bit kill;
        kill = fault;
`ifdef PWM_FAULT_LATCH_EN
        kill = kill | faultL;
        expectEq("fault_latched", longint'(fault_latched), longint'(faultL));
`endif
        for (int k = 0; k < int'(N_CH); k++) begin
            eP[k] = mOut(k, 1'b1) && !kill;
            eN[k] = mOut(k, 1'b0) && !kill;
        end
        expectEq("carrier", longint'(carrier), longint'(mCarrier()));
        expectEq("carrier_up", longint'(carrier_up), longint'(mUp()));
        expectEq("sync", longint'(sync), longint'(wrapped));
        expectEq("out_p", longint'(out_p), longint'(eP));
        expectEq("out_n", longint'(out_n), longint'(eN));
        expectEq("overlap", longint'(out_p & out_n), 0);
        obsP = out_p; obsN = out_n; obsSync = sync;
    endtask

    // One clock cycle: drive, check mid-cycle, advance model at the edge
    task automatic step(input bit en, input bit ld, input bit flt);
        enable = en; load = ld; fault = flt;
        #1;
        compareAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic setDutyAll(input int v);
        for (int k = 0; k < int'(N_CH); k++) duty[k*W +: W] = W'(v);
    endtask

    task automatic runUntilCarrier(input int c, input bit up, input int bound);
        int n;
        n = 0;
        while (!(mCarrier() == c && mUp() == up) && n < bound) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= bound) expectEq("wait_carrier_timeout", n, 0);
    endtask

    task automatic runUntilValley(input int bound);
        int n;
        n = 0;
        while (!wrapped && n < bound) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= bound) expectEq("wait_valley_timeout", n, 0);
    endtask

    // Count output-high cycles of channel ch over one carrier cycle
    task automatic measurePeriod(input int ch, output int pHi, output int nHi, output int both);
        pHi = 0; nHi = 0; both = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            pHi += int'(obsP[ch]);
            nHi += int'(obsN[ch]);
            if (!obsP[ch] && !obsN[ch]) both++;
        end
    endtask

    initial begin
        int syncSeen, lastSync, pHi, nHi, both, r;
        bit ld;
        total = 0; bad = 0;
        reset = 1'b1; enable = 1'b0; load = 1'b0; fault = 1'b0;
        period = W'(100); duty = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        expectEq("rst_carrier", longint'(carrier), 0);
        expectEq("rst_up", longint'(carrier_up), 1);
        expectEq("rst_sync", longint'(sync), 0);
        expectEq("rst_out_p", longint'(out_p), 0);
        expectEq("rst_out_n", longint'(out_n), 0);
        reset = 1'b0;

        // Period 100, duty 50 loaded on the first cycle, active from the first valley
        setDutyAll(50);
        step(1'b1, 1'b1, 1'b0);
        syncSeen = 0; lastSync = -1; pHi = 0; nHi = 0; both = 0;
        for (int cyc = 1; cyc < 700; cyc++) begin
            step(1'b1, 1'b0, 1'b0);
            if (obsSync) begin
                if (lastSync >= 0) expectEq("sync_gap", cyc - lastSync, 200);
                lastSync = cyc;
                syncSeen++;
            end
            if (syncSeen == 2) begin
                pHi += int'(obsP[0]);
                nHi += int'(obsN[0]);
                if (!obsP[0] && !obsN[0]) both++;
            end
        end
        expectEq("sync_count", syncSeen, 3);
        expectEq("d50_p_high", pHi, 94);
        expectEq("d50_n_high", nHi, 96);
        expectEq("d50_both_low", both, 10);

        // Load 80 mid-period, overwrite with 70 before the valley
        runUntilCarrier(40, 1'b1, 400);
        setDutyAll(80);
        step(1'b1, 1'b1, 1'b0);
        runUntilCarrier(90, 1'b1, 400);
        setDutyAll(70);
        step(1'b1, 1'b1, 1'b0);
        runUntilValley(400);
        measurePeriod(1, pHi, nHi, both);
        expectEq("d70_p_high", pHi, 134);
        expectEq("d70_n_high", nHi, 56);

        // Duty 2: the 3-cycle raw pulse is swallowed by the dead time
        runUntilCarrier(40, 1'b1, 400);
        setDutyAll(2);
        step(1'b1, 1'b1, 1'b0);
        runUntilValley(400);
        measurePeriod(2, pHi, nHi, both);
        measurePeriod(2, pHi, nHi, both);
        expectEq("d2_p_high", pHi, 0);
        expectEq("d2_n_high", nHi, 192);

        // Fault while the high sides are on
        setDutyAll(50);
        step(1'b1, 1'b1, 1'b0);
        runUntilValley(400);
        step(1'b1, 1'b0, 1'b0);
        runUntilCarrier(30, 1'b1, 400);
        step(1'b1, 1'b0, 1'b1);
        expectEq("fault_kill_p", longint'(obsP), 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
`ifdef PWM_FAULT_LATCH_EN
        expectEq("fault_sticky_p", longint'(obsP), 0);
        step(1'b0, 1'b0, 1'b0);
        runUntilCarrier(20, 1'b1, 400);
`else
        expectEq("fault_resume_p", longint'(obsP), 7);
`endif

        // Random run: period, duty, load, enable and fault all vary
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) period = W'($urandom_range(0, 60));
            ld = (r >= 3 && r < 10);
            if (ld) begin
                for (int k = 0; k < int'(N_CH); k++) duty[k*W +: W] = W'($urandom_range(0, curP + 3));
            end
            step($urandom_range(0, 199) != 0, ld, $urandom_range(0, 149) == 0);
        end

        // Async reset on the down slope at carrier 73
        period = W'(100);
        runUntilCarrier(73, 1'b0, 2000);
        #2;
        reset = 1'b1;
        #1;
        expectEq("arst_carrier", longint'(carrier), 0);
        expectEq("arst_up", longint'(carrier_up), 1);
        expectEq("arst_out_p", longint'(out_p), 0);
        expectEq("arst_out_n", longint'(out_n), 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        setDutyAll(50);
        step(1'b1, 1'b1, 1'b0);
        syncSeen = 0; lastSync = -1;
        for (int cyc = 1; cyc < 450; cyc++) begin
            step(1'b1, 1'b0, 1'b0);
            if (obsSync) begin
                if (lastSync >= 0) expectEq("restart_sync_gap", cyc - lastSync, 200);
                else expectEq("restart_first_sync", cyc, 200);
                lastSync = cyc;
                syncSeen++;
            end
        end
        expectEq("restart_sync_count", syncSeen, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
